elbeth_alu_arbiter: RTL and testbench

Shares the single combinational elbeth_alu between two requesters: port 0 (core datapath) and port 1 (multicycle/debug unit).
- Accepts operations over valid/ready handshakes.
- Drives the ALU from registered operands.
- Captures the result and returns it on a response channel tagged with the requester ID.
- Sits between the requesters and elbeth_alu, which is instantiated alongside it and connected through the alu_* ports.

---
 rtl/elbeth_alu_defs.sv | 25 ++
 rtl/elbeth_rr_arb2.sv | 46 ++++
 rtl/elbeth_alu_arbiter.sv | 131 +++++++++++++
 tb/tb_elbeth_alu_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_alu_defs.sv
// elbeth_alu_defs: opcode constants and arbiter FSM encoding shared by
// elbeth_alu, elbeth_alu_arbiter and their benches.
package elbeth_alu_defs;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_AND  = 4'd2;
    localparam logic [3:0] ALU_OP_OR   = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_SLT  = 4'd5;
    localparam logic [3:0] ALU_OP_SLTU = 4'd6;
    localparam logic [3:0] ALU_OP_SLL  = 4'd7;
    localparam logic [3:0] ALU_OP_SRL  = 4'd8;
    localparam logic [3:0] ALU_OP_SRA  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/elbeth_rr_arb2.sv
// elbeth_rr_arb2: two-way combinational grant.
// A lone valid requester is granted; on contention the port that did not win
// last time is granted, unless ELBETH_ALU_ARB_FIXED_PRIO_EN is defined, in
// which case port 0 always wins.
module elbeth_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_id_o
);

`ifdef ELBETH_ALU_ARB_FIXED_PRIO_EN
    // History is not consulted under fixed priority.
    logic unused_last_s;
    assign unused_last_s = last_grant_i;
`endif

    // Pick the winning port from the valid pair.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_id_o    = 1'b0;
        case (valid_i)
            2'b01: begin
                grant_valid_o = 1'b1;
                grant_id_o    = 1'b0;
            end
            2'b10: begin
                grant_valid_o = 1'b1;
                grant_id_o    = 1'b1;
            end
            2'b11: begin
                grant_valid_o = 1'b1;
`ifdef ELBETH_ALU_ARB_FIXED_PRIO_EN
                grant_id_o    = 1'b0;
`else
                grant_id_o    = ~last_grant_i;
`endif
            end
            default: begin
                grant_valid_o = 1'b0;
                grant_id_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/elbeth_alu_arbiter.sv
// elbeth_alu_arbiter: shares one combinational elbeth_alu between two
// requesters. IDLE grants a port and registers its operands onto alu_*,
// EXEC lets the ALU settle and captures its result, RESP holds the tagged
// response until the consumer takes it.
// Optional macro: ELBETH_ALU_ARB_FIXED_PRIO_EN (port 0 always wins contention).
module elbeth_alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data
);

    import elbeth_alu_defs::*;

    arb_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;

    logic              grant_valid_s;
    logic              grant_id_s;

    elbeth_rr_arb2 u_arb (
        .valid_i       ({req1_valid, req0_valid}),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid_s),
        .grant_id_o    (grant_id_s)
    );

    // Next-state, ready strobes and register updates for each FSM phase.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    req0_ready   = ~grant_id_s;
                    req1_ready   = grant_id_s;
                    alu_a_d      = grant_id_s ? req1_a  : req0_a;
                    alu_b_d      = grant_id_s ? req1_b  : req0_b;
                    alu_op_d     = grant_id_s ? req1_op : req0_op;
                    resp_id_d    = grant_id_s;
                    last_grant_d = grant_id_s;
                    state_d      = EXEC;
                end else begin
                    state_d      = IDLE;
                end
            end
            EXEC: begin
                // ALU inputs have been stable for a full cycle here.
                resp_data_d  = alu_result;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    state_d      = RESP;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset favours port 0 on first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= {DATA_W{1'b0}};
            alu_a_q      <= {DATA_W{1'b0}};
            alu_b_q      <= {DATA_W{1'b0}};
            alu_op_q     <= OP_W'(ALU_OP_ADD);
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_elbeth_alu_arbiter.sv
// Bench for elbeth_alu_arbiter: a stand-in elbeth_alu, a latency-based
// transaction model, a per-cycle compare process, directed scenarios and a
// randomized phase.
module tb_elbeth_alu_arbiter;

    import elbeth_alu_defs::*;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OW-1:0] req0_op, req1_op;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [OW-1:0] alu_op;
    logic          resp_valid, resp_ready, resp_id;
    logic [DW-1:0] resp_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OW-1:0] op);
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_AND:  return a & b;
            ALU_OP_OR:   return a | b;
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_OP_SLL:  return a << b[4:0];
            ALU_OP_SRL:  return a >> b[4:0];
            ALU_OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            default:     return 32'd0;
        endcase
    endfunction

    // Stand-in for elbeth_alu on the alu_* ports.
    assign alu_result = alu_fn(alu_a, alu_b, alu_op);

    elbeth_alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arbitration rule: -1 none, otherwise the winning port.
    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
`ifdef ELBETH_ALU_ARB_FIXED_PRIO_EN
            return 0;
`else
            return last ? 0 : 1;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // ---------------- transaction model ----------------
    // One operation in flight at most; its result becomes visible one edge
    // after the grant and can be consumed from the edge after that.
    int unsigned   cyc = 0;
    int unsigned   m_gcyc = 0;
    int            m_g;
    logic          m_busy, m_last, m_rid;
    logic [DW-1:0] m_prev, m_new, m_a, m_b;
    logic [OW-1:0] m_op;

    function automatic logic m_has_result();
        return m_busy && (cyc >= m_gcyc + 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b1; m_rid = 1'b0;
            m_prev = '0; m_new = '0; m_a = '0; m_b = '0; m_op = '0;
        end else begin
            cyc++;
            if (!m_busy) begin
                m_g = pick(req0_valid, req1_valid, m_last);
                if (m_g >= 0) begin
                    m_busy = 1'b1;
                    m_gcyc = cyc;
                    m_last = (m_g == 1);
                    m_rid  = (m_g == 1);
                    m_a    = (m_g == 1) ? req1_a  : req0_a;
                    m_b    = (m_g == 1) ? req1_b  : req0_b;
                    m_op   = (m_g == 1) ? req1_op : req0_op;
                    m_new  = alu_fn(m_a, m_b, m_op);
                end
            end else if (cyc >= m_gcyc + 2 && resp_ready) begin
                m_busy = 1'b0;
                m_prev = m_new;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int c_g;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            c_g = pick(req0_valid, req1_valid, m_last);
            chk("req0_ready", 64'(req0_ready), 64'(!m_busy && c_g == 0));
            chk("req1_ready", 64'(req1_ready), 64'(!m_busy && c_g == 1));
            chk("resp_valid", 64'(resp_valid), 64'(m_has_result()));
            chk("resp_id",    64'(resp_id),    64'(m_rid));
            chk("resp_data",  64'(resp_data),  64'(m_has_result() ? m_new : m_prev));
            chk("alu_a",      64'(alu_a),      64'(m_a));
            chk("alu_b",      64'(alu_b),      64'(m_b));
            chk("alu_op",     64'(alu_op),     64'(m_op));
        end
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        logic          id;
        logic [DW-1:0] d;
    } resp_t;
    resp_t rq[$];

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Present up to two requests, collect nresp responses (bounded wait).
    task automatic do_ops(input logic v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                          input logic [OW-1:0] op0,
                          input logic v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                          input logic [OW-1:0] op1,
                          input bit persist, input int nresp);
        logic p0, p1;
        int   t;
        p0 = v0; p1 = v1; t = 0;
        rq.delete();
        while (rq.size() < nresp && t < 200) begin
            @(negedge clk);
            req0_valid = p0; req0_a = a0; req0_b = b0; req0_op = op0;
            req1_valid = p1; req1_a = a1; req1_b = b1; req1_op = op1;
            #3;
            if (req0_valid && req0_ready && !persist) p0 = 1'b0;
            if (req1_valid && req1_ready && !persist) p1 = 1'b0;
            if (resp_valid && resp_ready) rq.push_back('{resp_id, resp_data});
            t++;
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("resp_count", 64'(rq.size()), 64'(nresp));
    endtask

    function automatic logic [DW-1:0] rnd_data();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    logic took0, took1;
    logic exp_id;
    initial begin
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_resp_valid", 64'(resp_valid), 64'(1'b0));
        chk("rst_resp_data",  64'(resp_data),  64'(32'd0));
        chk("rst_alu_op",     64'(alu_op),     64'(4'd0));
        @(negedge clk); rst = 1'b0;

        // 1: single port 0 ADD 3+4
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = ALU_OP_ADD;
        #3 chk("t1_ready", 64'(req0_ready), 64'(1'b1));
        @(negedge clk); req0_valid = 1'b0;
        #3 chk("t1_ready_drop", 64'(req0_ready), 64'(1'b0));
        chk("t1_exec_no_resp", 64'(resp_valid), 64'(1'b0));
        @(negedge clk);
        #3 chk("t1_resp_valid", 64'(resp_valid), 64'(1'b1));
        chk("t1_resp_id",   64'(resp_id),   64'(1'b0));
        chk("t1_resp_data", 64'(resp_data), 64'(32'd7));
        @(negedge clk);
        #3 chk("t1_resp_done", 64'(resp_valid), 64'(1'b0));

        // 2: contention right after reset, port 0 first
        pulse_reset();
        do_ops(1'b1, 32'd5, 32'd2, ALU_OP_SUB, 1'b1, 32'd10, 32'd5, ALU_OP_OR, 1'b0, 2);
        chk("t2_first_id",    64'(rq[0].id), 64'(1'b0));
        chk("t2_first_data",  64'(rq[0].d),  64'(32'd3));
        chk("t2_second_id",   64'(rq[1].id), 64'(1'b1));
        chk("t2_second_data", 64'(rq[1].d),  64'(32'd15));

        // 3: stalled response on SLT, port 1 waiting behind it
        resp_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_op = ALU_OP_SLT;
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_op = ALU_OP_ADD;
        #3 chk("t3_p0_ready", 64'(req0_ready), 64'(1'b1));
        @(negedge clk); req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #3;
            chk("t3_hold_valid", 64'(resp_valid), 64'(1'b1));
            chk("t3_hold_data",  64'(resp_data),  64'(32'd1));
            chk("t3_hold_r0",    64'(req0_ready), 64'(1'b0));
            chk("t3_hold_r1",    64'(req1_ready), 64'(1'b0));
        end
        @(negedge clk); resp_ready = 1'b1;
        #3 chk("t3_still_valid", 64'(resp_valid), 64'(1'b1));
        @(negedge clk);
        #3 chk("t3_p1_ready", 64'(req1_ready), 64'(1'b1));
        @(negedge clk); req1_valid = 1'b0;
        @(negedge clk);
        #3 chk("t3_p1_id",   64'(resp_id),   64'(1'b1));
        chk("t3_p1_data", 64'(resp_data), 64'(32'd14));
        @(negedge clk);

        // 4: both ports continuously valid for six operations
        pulse_reset();
        do_ops(1'b1, 32'd1, 32'd1, ALU_OP_ADD, 1'b1, 32'd2, 32'd2, ALU_OP_ADD, 1'b1, 6);
        for (int i = 0; i < 6; i++) begin
`ifdef ELBETH_ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (i % 2 == 1);
`endif
            chk("t4_id_seq",   64'(rq[i].id), 64'(exp_id));
            chk("t4_data_seq", 64'(rq[i].d),  64'(exp_id ? 32'd4 : 32'd2));
        end

        // 5: async reset during EXEC of port 1, then during RESP of port 0
        pulse_reset();
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_op = ALU_OP_ADD;
        #3 chk("t5_p1_ready", 64'(req1_ready), 64'(1'b1));
        @(negedge clk); req1_valid = 1'b0;
        #3 rst = 1'b1;
        #1 chk("t5_exec_rst_valid", 64'(resp_valid), 64'(1'b0));
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3 chk("t5_no_resp", 64'(resp_valid), 64'(1'b0));
        end
        resp_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_op = ALU_OP_ADD;
        @(negedge clk); req0_valid = 1'b0;
        @(negedge clk);
        #3 chk("t5_resp_up", 64'(resp_valid), 64'(1'b1));
        #1 rst = 1'b1;
        #1 chk("t5_resp_rst_valid", 64'(resp_valid), 64'(1'b0));
        @(negedge clk); rst = 1'b0; resp_ready = 1'b1;
        do_ops(1'b1, 32'd9, 32'd1, ALU_OP_SUB, 1'b1, 32'd1, 32'd1, ALU_OP_ADD, 1'b0, 2);
        chk("t5_after_rst_id",   64'(rq[0].id), 64'(1'b0));
        chk("t5_after_rst_data", 64'(rq[0].d),  64'(32'd8));

        // 6: wrap-around passes straight through
        do_ops(1'b1, 32'hFFFF_FFFF, 32'd1, ALU_OP_ADD, 1'b0, 32'd0, 32'd0, ALU_OP_ADD, 1'b0, 1);
        chk("t6_wrap_data", 64'(rq[0].d), 64'(32'd0));

        // randomized traffic, requests held until accepted
        took0 = 1'b1; took1 = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!req0_valid || took0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a = rnd_data(); req0_b = rnd_data(); req0_op = OW'($urandom_range(0, 11));
            end
            if (!req1_valid || took1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a = rnd_data(); req1_b = rnd_data(); req1_op = OW'($urandom_range(0, 11));
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            #3;
            took0 = req0_valid && req0_ready;
            took1 = req1_valid && req1_ready;
            if (i % 500 == 250) begin
                #1 rst = 1'b1;
                @(negedge clk); rst = 1'b0;
                took0 = 1'b1; took1 = 1'b1;
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        repeat (4) @(negedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
